// File: rtl/seq_mul_param_if.sv
// rtl/seq_mul_param_if.sv - start/busy/done handshake and operand/product bus of seq_mul_param
interface seq_mul_param_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - shift-add multiplier, one multiplier bit per clock; SEQ_MUL_EARLY_TERM_EN enables early exit
module seq_mul_param #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_mul_param_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    acc_sum;
    logic             last_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
        end
    end

    always_comb begin
        // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
        a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? (WIDTH'(0) - bus.a) : bus.a;
        b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? (WIDTH'(0) - bus.b) : bus.b;
        acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef SEQ_MUL_EARLY_TERM_EN
        last_step = (cnt_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) begin
                    product_d = neg_q ? (PW'(0) - acc_sum) : acc_sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule
